// File: rtl/he_frame_sched.sv
// Frame scheduler for the two-frame RGB histogram-equalisation cycle (statistics frame, then mapping frame).
// Generates end-of-frame, delay-FIFO write gate and phase, tracks drain and flags FIFO overflow / short frames.
module he_frame_sched #(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vsync,
    input  logic in_valid,
    input  logic core_dst_valid,
    input  logic err_clr,
    output logic pix_last,
    output logic fifo_wr_en,
    output logic phase,
    output logic busy,
    output logic frame_done,
    output logic err_overflow,
    output logic err_short_frame
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int OW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 2);

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [OW-1:0] O_FULL  = OW'(NPIX);
    localparam logic [OW-1:0] O_PEN   = OW'(NPIX - 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_SAT   = CW'(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, STAT, WAIT_MAP, MAP, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [OW-1:0] out_q, out_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          phase_q, phase_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          ovf_q, ovf_d;
    logic          short_q, short_d;

    logic last_pix;
    logic pix_nz;
    logic ovf_set;
    logic short_set;
    logic out_active;

    assign last_pix   = (x_q == X_LAST) && (y_q == Y_LAST);
    assign pix_nz     = (x_q != '0) || (y_q != '0);
    assign out_active = (state_q == MAP) || (state_q == DRAIN);

    assign pix_last   = in_valid && ((state_q == STAT) || (state_q == MAP)) && last_pix;
    assign fifo_wr_en = in_valid && (state_q == MAP);

    // A write that would push the credit past FIFO_DEPTH is an overflow event, even when already saturated
    assign ovf_set = fifo_wr_en && !core_dst_valid && (cred_q >= C_DEPTH);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        out_d        = out_q;
        cred_d       = cred_q;
        short_set    = 1'b0;
        frame_done_d = 1'b0;

        case ({fifo_wr_en, core_dst_valid})
            2'b10:   if (cred_q != C_SAT) cred_d = cred_q + 1'b1;
            2'b01:   if (cred_q != '0)    cred_d = cred_q - 1'b1;
            default: cred_d = cred_q;
        endcase

        if (out_active && core_dst_valid && (out_q != O_FULL)) begin
            out_d        = out_q + 1'b1;
            frame_done_d = (out_q == O_PEN);
        end

        case (state_q)
            IDLE: begin
                if (in_vsync) begin
                    state_d = STAT;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            STAT, MAP: begin
                if (in_vsync) begin
                    short_set = pix_nz;
                    x_d       = '0;
                    y_d       = '0;
                    if (state_q == MAP) begin
                        if (pix_nz) begin
                            state_d = STAT;
                        end else begin
                            out_d  = '0;
                            cred_d = '0;
                        end
                    end
                end else if (in_valid) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (last_pix) state_d = (state_q == STAT) ? WAIT_MAP : DRAIN;
                end
            end
            WAIT_MAP: begin
                if (in_vsync) begin
                    state_d = MAP;
                    x_d     = '0;
                    y_d     = '0;
                    out_d   = '0;
                    cred_d  = '0;
                end
            end
            DRAIN: begin
                if (out_q == O_FULL) begin
                    state_d = in_vsync ? STAT : IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ovf_d   = ovf_q;
        short_d = short_q;
        if (err_clr) begin
            ovf_d   = 1'b0;
            short_d = 1'b0;
        end
        if (ovf_set)   ovf_d   = 1'b1;
        if (short_set) short_d = 1'b1;

        phase_d = (state_d == WAIT_MAP) || (state_d == MAP) || (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            out_q        <= '0;
            cred_q       <= '0;
            phase_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            out_q        <= out_d;
            cred_q       <= cred_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
            short_q      <= short_d;
        end
    end

    assign phase           = phase_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign err_overflow    = ovf_q;
    assign err_short_frame = short_q;

endmodule

// File: tb/tb_he_frame_sched.sv
// Bench for he_frame_sched on a 4x2 frame with a 4-entry FIFO: a directed vector table,
// hand sequences for short frame / overflow-vs-clear / async reset, then random traffic against a frame-level model.
module tb_he_frame_sched;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_vsync = 1'b0, in_valid = 1'b0, core_dst_valid = 1'b0, err_clr = 1'b0;
    logic pix_last, fifo_wr_en, phase, busy, frame_done, err_overflow, err_short_frame;

    int n_cmp = 0;
    int n_err = 0;

    he_frame_sched #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_valid(in_valid),
        .core_dst_valid(core_dst_valid), .err_clr(err_clr), .pix_last(pix_last),
        .fifo_wr_en(fifo_wr_en), .phase(phase), .busy(busy), .frame_done(frame_done),
        .err_overflow(err_overflow), .err_short_frame(err_short_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic vs, v, core, clr;
        logic pl, wr, ph, bz, dn, ov, sh;
    } vec_t;

    vec_t tbl[29];

    // Frame-level reference: mode 0 idle, 1 histogram frame, 2 waiting for mapping frame, 3 mapping, 4 draining
    int m_mode, m_pix, m_out, m_cred;
    bit m_ph, m_bz, m_dn, m_ov, m_sh;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pix = 0; m_out = 0; m_cred = 0;
        m_ph = 0; m_bz = 0; m_dn = 0; m_ov = 0; m_sh = 0;
    endtask

    task automatic model_step(input bit vs, input bit v, input bit core, input bit clr);
        bit wr, ovs, shs;
        int nmode, npix, nout, ncred;
        wr = v && (m_mode == 3);
        nmode = m_mode; npix = m_pix; nout = m_out; ncred = m_cred;
        ovs = wr && !core && (m_cred >= D);
        shs = 0;
        if (wr && !core) ncred = (m_cred < D + 1) ? m_cred + 1 : m_cred;
        else if (core && !wr) ncred = (m_cred > 0) ? m_cred - 1 : 0;
        m_dn = 0;
        if ((m_mode == 3 || m_mode == 4) && core && m_out < N) begin
            nout = m_out + 1;
            m_dn = (nout == N);
        end
        case (m_mode)
            0: if (vs) begin nmode = 1; npix = 0; end
            1, 3: begin
                if (vs) begin
                    shs = (m_pix != 0);
                    npix = 0;
                    if (m_mode == 3) begin
                        if (m_pix != 0) nmode = 1;
                        else begin nout = 0; ncred = 0; end
                    end
                end else if (v) begin
                    if (m_pix == N - 1) begin
                        npix = 0;
                        nmode = (m_mode == 1) ? 2 : 4;
                    end else npix = m_pix + 1;
                end
            end
            2: if (vs) begin nmode = 3; npix = 0; nout = 0; ncred = 0; end
            4: if (m_out == N) nmode = vs ? 1 : 0;
            default: nmode = 0;
        endcase
        if (clr) begin m_ov = 0; m_sh = 0; end
        if (ovs) m_ov = 1;
        if (shs) m_sh = 1;
        m_mode = nmode; m_pix = npix; m_out = nout; m_cred = ncred;
        m_ph = (nmode >= 2);
        m_bz = (nmode != 0);
    endtask

    task automatic drive(input bit vs, input bit v, input bit core, input bit clr);
        in_vsync = vs; in_valid = v; core_dst_valid = core; err_clr = clr;
        #1;
        chk("pix_last", pix_last, v && (m_mode == 1 || m_mode == 3) && (m_pix == N - 1));
        chk("fifo_wr_en", fifo_wr_en, v && (m_mode == 3));
        chk("phase", phase, m_ph);
        chk("busy", busy, m_bz);
        chk("frame_done", frame_done, m_dn);
        chk("err_overflow", err_overflow, m_ov);
        chk("err_short_frame", err_short_frame, m_sh);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(in_vsync, in_valid, core_dst_valid, err_clr);
        #1;
    endtask

    task automatic cyc(input bit vs, input bit v, input bit core, input bit clr);
        drive(vs, v, core, clr);
        tick();
    endtask

    initial begin
        // Rows: stats frame + 3 stray pixels, then mapping frame with core returning each pixel 5 cycles later
        for (int i = 0; i < 29; i++) begin
            tbl[i].vs   = (i == 0 || i == 12);
            tbl[i].v    = (i >= 1 && i <= 11) || (i >= 13 && i <= 20);
            tbl[i].core = (i >= 18 && i <= 25);
            tbl[i].clr  = (i == 27);
            tbl[i].pl   = (i == 8 || i == 20);
            tbl[i].wr   = (i >= 13 && i <= 20);
            tbl[i].ph   = (i >= 9 && i <= 26);
            tbl[i].bz   = (i >= 1 && i <= 26);
            tbl[i].dn   = (i == 26);
            tbl[i].ov   = (i >= 18 && i <= 27);
            tbl[i].sh   = 1'b0;
        end

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            in_vsync = tbl[i].vs; in_valid = tbl[i].v;
            core_dst_valid = tbl[i].core; err_clr = tbl[i].clr;
            #1;
            chk("tbl pix_last", pix_last, tbl[i].pl);
            chk("tbl fifo_wr_en", fifo_wr_en, tbl[i].wr);
            chk("tbl phase", phase, tbl[i].ph);
            chk("tbl busy", busy, tbl[i].bz);
            chk("tbl frame_done", frame_done, tbl[i].dn);
            chk("tbl err_overflow", err_overflow, tbl[i].ov);
            chk("tbl err_short_frame", err_short_frame, tbl[i].sh);
            @(posedge clk);
            #1;
        end

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();

        // Short frame: vsync after 5 pixels, then a full 8-pixel frame
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("short set", err_short_frame, 1'b1);
        for (int k = 1; k <= N; k++) begin
            drive(0, 1, 0, 0);
            chk("short pix_last", pix_last, k == N);
            chk("short still stat", phase, 1'b0);
            tick();
        end
        chk("short -> wait_map", phase, 1'b1);
        cyc(0, 0, 0, 1);
        chk("short cleared", err_short_frame, 1'b0);

        // Overflow, then clear colliding with a fresh overflow event
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0);
        chk("ovf before 5th", err_overflow, 1'b0);
        cyc(0, 1, 0, 0);
        chk("ovf after 5th", err_overflow, 1'b1);
        cyc(0, 1, 0, 1);
        chk("ovf set beats clr", err_overflow, 1'b1);
        cyc(0, 0, 0, 1);
        chk("ovf cleared", err_overflow, 1'b0);
        repeat (2) cyc(0, 1, 0, 0);
        repeat (N) cyc(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("drain frame_done", frame_done, 1'b1);
        tick();
        drive(0, 0, 0, 0);
        chk("frame_done one cycle", frame_done, 1'b0);
        chk("idle after drain", busy, 1'b0);
        tick();

        // Async reset during the third mapping pixel
        cyc(1, 0, 0, 0);
        repeat (N) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst fifo_wr_en", fifo_wr_en, 1'b0);
        chk("rst pix_last", pix_last, 1'b0);
        chk("rst phase", phase, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst frame_done", frame_done, 1'b0);
        chk("rst err_overflow", err_overflow, 1'b0);
        chk("rst err_short_frame", err_short_frame, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            chk("post-rst no write", fifo_wr_en, 1'b0);
            tick();
        end

        // Random traffic against the reference model
        for (int k = 0; k < 2500; k++) begin
            cyc(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 16) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
